tpi_irq_ctrl: RTL and testbench
===============================

Name: tpi_irq_ctrl

Overview:
- Interrupt-mode companion to the tri-port I/O block. It sits between the port C pins and the CPU bus decoder.
- Five port C inputs (I0..I4) are edge-detected and latched into an interrupt latch register (ILR), then masked and prioritised.
- Drives a single IRQ output, which the top level routes to PC5 / the CPU.
- Adds the CR (rs=6) and AIR (rs=7) registers. It also provides mask (rs=5) and ILR readback (rs=2) when the top level selects interrupt mode.

Parameters:
- NUM_IRQ, 5, number of interrupt inputs; I(NUM_IRQ-1) has the highest priority.
- SYNC_STAGES, 2, synchroniser flops per input before edge detection (minimum 2).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  chip select qualified by the top level (interrupt mode enabled and _cs low).
- rs  input  3  register select.
- wr_stb  input  1  one-cycle write strobe, valid with sel.
- rd_stb  input  1  one-cycle read strobe, valid with sel; triggers read side effects.
- data_in  input  8  CPU write data.
- data_out  output  8  read data for rs 2,5,6,7; 0 for other rs values.
- irq_pins  input  NUM_IRQ  raw asynchronous port C inputs.
- irq  output  1  registered, active-high interrupt request.

Behaviour:
Reset:
- ILR, MASK, CR, ISR (in-service) and irq are all 0.
- Synchroniser and edge history flops are loaded with 1, so the first sampled low does not produce a falling edge.

Edge detection and latching:
- I0..I2 latch on a falling edge.
- I3 latches on a rising edge if CR[1]=1, otherwise on a falling edge. I4 uses CR[2] the same way.
- Latency: a pin change sampled at clock edge N sets its ILR bit at edge N+SYNC_STAGES+1. irq updates one edge later.
- Edges are latched regardless of MASK. MASK only gates irq and AIR.

Registers:
- rs=2 read: {2'b00, irq, ILR[4:0]}. Write has no effect.
- rs=5 read/write: MASK[4:0]; bits 7:5 read 0.
- rs=6 read/write: CR. CR[0]=prio_en, CR[1]=i3_rise, CR[2]=i4_rise. Bits 7:3 read 0 and writes to them are ignored.
- Definition: P = ILR & MASK.

Non-priority mode (CR[0]=0):
- irq = |P.
- AIR read returns {3'b0, P}, with no side effect.
- AIR write clears the ILR bits where data_in=1.

Priority mode (CR[0]=1):
- H = highest set bit of P that is above the highest set bit of ISR. An empty ISR counts as below all levels.
- irq = H exists.
- AIR read returns one-hot H (0 if none) and sets ISR[H].
- AIR write (data ignored) clears the highest set ISR bit and the matching ILR bit. A write with ISR=0 does nothing.
- Nesting is unbounded up to NUM_IRQ levels, because each level occupies its own ISR bit.

Switching CR[0] from 1 to 0 clears ISR in the same cycle.

Simultaneous events:
- An edge-set and a write-clear of the same ILR bit in one cycle: the set wins (bit ends at 1).
- An AIR read and a new higher-priority edge in one cycle: the read returns the H computed from pre-edge state.
- An MASK write takes effect on irq at the next edge.
- A reset in mid-service discards ILR, ISR and any pending edges.

data_out is combinational from the registers and rs. The read side effect commits at the edge where rd_stb=1.

Decomposition:
- Package tpi_pkg holds:
  - constants RS_PRC=2, RS_DDRC=5, RS_CR=6, RS_AIR=7;
  - CR bit indices CR_PRIO=0, CR_I3R=1, CR_I4R=2;
  - NUM_IRQ default;
  - a priority-encode function (highest set bit to index plus valid).
- One sub-module, tpi_edge_sync, is instantiated per input: SYNC_STAGES-flop synchroniser, history flop, a rise/fall select input, and a one-cycle edge pulse output.
- Register file, ILR/ISR logic and the irq flop stay in the top module.

Test Plan:
- Reset, then read rs 2,5,6,7 -> all return 0x00, irq=0. Pulse I0 low with MASK=0 -> ILR=0x01 at N+3, irq stays 0.
- MASK=0x1F, CR=0x00, falling edge on I2 -> rs2 reads 0x24, then AIR reads 0x04; AIR write 0x04 -> ILR=0, irq=0 one edge later.
- CR=0x02, rising edge on I3 -> ILR[3]=1; a falling edge on I3 does not set it; CR=0x00 then falling edge on I3 -> sets it.
- CR=0x01, MASK=0x1F, edges on I1 then I4:
  - AIR read returns 0x10 (ISR=0x10) and irq drops.
  - AIR write -> irq rises (I1 pending); AIR read returns 0x02.
  - AIR write -> ILR=0, ISR=0, irq=0.
- Priority nesting: service I1 (AIR read gives 0x02), then an edge on I3 -> irq=1. AIR read gives 0x08; first AIR write clears ISR[3] only; second clears ISR[1].
- Same-cycle falling edge pulse and AIR write clearing that bit in non-priority mode -> bit remains 1. Assert reset while ISR=0x0A -> all registers 0 next edge.

Source files
------------

// File: rtl/tpi_pkg.sv
// Shared constants and helpers for the tri-port I/O interrupt controller.
package tpi_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 5;

    localparam logic [2:0] RS_PRC  = 3'd2;
    localparam logic [2:0] RS_DDRC = 3'd5;
    localparam logic [2:0] RS_CR   = 3'd6;
    localparam logic [2:0] RS_AIR  = 3'd7;

    localparam int unsigned CR_PRIO = 0;
    localparam int unsigned CR_I3R  = 1;
    localparam int unsigned CR_I4R  = 2;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } prio_t;

    // Highest set bit wins; ascending scan lets later (higher) bits overwrite.
    function automatic prio_t prio_enc(input logic [7:0] vec);
        prio_t res;
        res.valid = 1'b0;
        res.idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tpi_edge_sync.sv
// Per-pin synchroniser and edge detector producing a registered one-cycle edge pulse.
module tpi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    input  logic rise_sel,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pulse_q;
    logic                   synced;
    logic                   detect;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        detect = 1'b0;
        if (rise_sel) begin
            detect = synced & ~hist_q;
        end else begin
            detect = ~synced & hist_q;
        end
    end

    // Idle-high reset so a quiet pin never looks like a fresh edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '1;
            hist_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q  <= synced;
            pulse_q <= detect;
        end
    end

    assign edge_pulse = pulse_q;

endmodule

// File: rtl/tpi_irq_ctrl.sv
// Port C interrupt controller: edge latch (ILR), mask, nested priority service (ISR), IRQ output.
module tpi_irq_ctrl
    import tpi_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sel,
    input  logic [2:0]         rs,
    input  logic               wr_stb,
    input  logic               rd_stb,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic [NUM_IRQ-1:0] irq_pins,
    output logic               irq
);

    logic [NUM_IRQ-1:0] ilr_q, ilr_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [2:0]         cr_q, cr_d;
    logic               irq_q, irq_d;

    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] above;
    logic [NUM_IRQ-1:0] h_onehot;
    prio_t              isr_top;
    prio_t              h;
    logic               prio_en;
    logic               rd_air, wr_air, wr_mask, wr_cr;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_in
        logic rise_sel;
        if (i == 3) begin : g_i3
            assign rise_sel = cr_q[CR_I3R];
        end else if (i == 4) begin : g_i4
            assign rise_sel = cr_q[CR_I4R];
        end else begin : g_fall
            assign rise_sel = 1'b0;
        end

        tpi_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clock     (clock),
            .reset     (reset),
            .pin       (irq_pins[i]),
            .rise_sel  (rise_sel),
            .edge_pulse(edge_set[i])
        );
    end

    assign prio_en = cr_q[CR_PRIO];
    assign pend    = ilr_q & mask_q;
    assign rd_air  = sel & rd_stb & (rs == RS_AIR);
    assign wr_air  = sel & wr_stb & (rs == RS_AIR);
    assign wr_mask = sel & wr_stb & (rs == RS_DDRC);
    assign wr_cr   = sel & wr_stb & (rs == RS_CR);

    // Only pending levels strictly above the one currently in service may interrupt.
    always_comb begin
        isr_top  = prio_enc(8'(isr_q));
        above    = '0;
        h_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            above[i] = ~isr_top.valid | (isr_top.idx < 3'(i));
        end
        h = prio_enc(8'(pend & above));
        for (int i = 0; i < NUM_IRQ; i++) begin
            h_onehot[i] = h.valid & (h.idx == 3'(i));
        end
        irq_d = prio_en ? h.valid : |pend;
    end

    always_comb begin
        ilr_d  = ilr_q;
        isr_d  = isr_q;
        mask_d = mask_q;
        cr_d   = cr_q;

        if (rd_air && prio_en) begin
            isr_d = isr_d | h_onehot;
        end
        if (wr_mask) begin
            mask_d = data_in[NUM_IRQ-1:0];
        end
        if (wr_cr) begin
            cr_d = data_in[2:0];
            if (!data_in[CR_PRIO]) begin
                isr_d = '0;
            end
        end
        if (wr_air) begin
            if (prio_en) begin
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (isr_top.valid && (isr_top.idx == 3'(i))) begin
                        isr_d[i] = 1'b0;
                        ilr_d[i] = 1'b0;
                    end
                end
            end else begin
                ilr_d = ilr_d & ~data_in[NUM_IRQ-1:0];
            end
        end
        // A new edge outranks a same-cycle clear.
        ilr_d = ilr_d | edge_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ilr_q  <= '0;
            isr_q  <= '0;
            mask_q <= '0;
            cr_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            ilr_q  <= ilr_d;
            isr_q  <= isr_d;
            mask_q <= mask_d;
            cr_q   <= cr_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (rs)
            RS_PRC: begin
                data_out[NUM_IRQ-1:0] = ilr_q;
                data_out[5]           = irq_q;
            end
            RS_DDRC: data_out[NUM_IRQ-1:0] = mask_q;
            RS_CR:   data_out[2:0]         = cr_q;
            RS_AIR:  data_out[NUM_IRQ-1:0] = prio_en ? h_onehot : pend;
            default: data_out = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_tpi_irq_ctrl.sv
// Self-checking bench for tpi_irq_ctrl: register vectors, directed sequences, randomized model check.
module tb_tpi_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic [2:0] rs = 3'd0;
    logic       wr_stb = 1'b0;
    logic       rd_stb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [4:0] irq_pins = 5'h1F;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    tpi_irq_ctrl #(
        .NUM_IRQ    (5),
        .SYNC_STAGES(2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .sel     (sel),
        .rs      (rs),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb),
        .data_in (data_in),
        .data_out(data_out),
        .irq_pins(irq_pins),
        .irq     (irq)
    );

    // Reference model: sampled-pin history plus spec-level register rules.
    logic [4:0] m_ilr, m_mask, m_isr, m_det_prev;
    logic [2:0] m_cr;
    logic       m_irq;
    logic [4:0] m_hist [3];

    function automatic int top_of(input logic [4:0] v);
        int t = -1;
        for (int i = 0; i < 5; i++) if (v[i]) t = i;
        return t;
    endfunction

    function automatic int m_h();
        logic [4:0] p = m_ilr & m_mask;
        int t = top_of(m_isr);
        int hh = -1;
        for (int i = 0; i < 5; i++) if (p[i] && i > t) hh = i;
        return hh;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] r);
        int hh = m_h();
        logic [7:0] v = 8'h00;
        case (r)
            3'd2: v = {2'b00, m_irq, m_ilr};
            3'd5: v = {3'b000, m_mask};
            3'd6: v = {5'b00000, m_cr};
            3'd7: begin
                if (m_cr[0]) v = (hh >= 0) ? (8'h01 << hh) : 8'h00;
                else         v = {3'b000, m_ilr & m_mask};
            end
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always @(posedge clock) begin : model
        logic [4:0] p, ilr_n, isr_n, mask_n, det;
        logic [2:0] cr_n;
        logic       a, b, rise;
        int         hh, t;
        if (reset) begin
            m_ilr = '0; m_mask = '0; m_isr = '0; m_cr = '0; m_irq = 1'b0;
            m_det_prev = '0;
            for (int k = 0; k < 3; k++) m_hist[k] = 5'h1F;
        end else begin
            p = m_ilr & m_mask;
            t = top_of(m_isr);
            hh = m_h();
            ilr_n = m_ilr; isr_n = m_isr; mask_n = m_mask; cr_n = m_cr;
            if (sel && rd_stb && rs == 3'd7 && m_cr[0] && hh >= 0) isr_n[hh] = 1'b1;
            if (sel && wr_stb) begin
                case (rs)
                    3'd5: mask_n = data_in[4:0];
                    3'd6: begin
                        cr_n = data_in[2:0];
                        if (!data_in[0]) isr_n = '0;
                    end
                    3'd7: begin
                        if (m_cr[0]) begin
                            if (t >= 0) begin
                                isr_n[t] = 1'b0;
                                ilr_n[t] = 1'b0;
                            end
                        end else begin
                            ilr_n = ilr_n & ~data_in[4:0];
                        end
                    end
                    default: ;
                endcase
            end
            for (int i = 0; i < 5; i++) begin
                a = m_hist[2][i];
                b = m_hist[1][i];
                rise = (i == 3 && m_cr[1]) || (i == 4 && m_cr[2]);
                det[i] = rise ? (!a && b) : (a && !b);
            end
            ilr_n = ilr_n | m_det_prev;
            m_det_prev = det;
            m_irq = m_cr[0] ? (hh >= 0) : (|p);
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = irq_pins;
            m_ilr = ilr_n; m_isr = isr_n; m_mask = mask_n; m_cr = cr_n;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h required %02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        chk("model irq", {7'b0, irq}, {7'b0, m_irq});
        chk("model data_out", data_out, m_read(rs));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        sel = 1'b1; wr_stb = 1'b1; rs = r; data_in = d;
        step();
        sel = 1'b0; wr_stb = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] r, input logic [7:0] exp, input string name);
        sel = 1'b1; rd_stb = 1'b1; rs = r;
        #1 chk(name, data_out, exp);
        step();
        sel = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic peek(input logic [2:0] r, input logic [7:0] exp, input string name);
        rs = r;
        #1 chk(name, data_out, exp);
    endtask

    typedef struct {
        bit         do_wr;
        logic [2:0] wrs;
        logic [7:0] wdata;
        logic [2:0] rrs;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b1, 3'd5, 8'h1F, 3'd5, 8'h1F};
        vecs[1]  = '{1'b1, 3'd5, 8'hFF, 3'd5, 8'h1F};
        vecs[2]  = '{1'b1, 3'd6, 8'hFF, 3'd6, 8'h07};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 3'd7, 8'h00};
        vecs[4]  = '{1'b1, 3'd6, 8'h00, 3'd6, 8'h00};
        vecs[5]  = '{1'b1, 3'd2, 8'hFF, 3'd2, 8'h00};
        vecs[6]  = '{1'b1, 3'd7, 8'hFF, 3'd7, 8'h00};
        vecs[7]  = '{1'b0, 3'd0, 8'h00, 3'd0, 8'h00};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd3, 8'h00};
        vecs[9]  = '{1'b1, 3'd5, 8'h0A, 3'd5, 8'h0A};
        vecs[10] = '{1'b1, 3'd5, 8'h00, 3'd5, 8'h00};

        steps(2);
        reset = 1'b0;
        step();
        rd_chk(3'd2, 8'h00, "reset rs2");
        rd_chk(3'd5, 8'h00, "reset rs5");
        rd_chk(3'd6, 8'h00, "reset rs6");
        rd_chk(3'd7, 8'h00, "reset rs7");
        chk("reset irq", {7'b0, irq}, 8'h00);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].wrs, vecs[i].wdata);
            rd_chk(vecs[i].rrs, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // I0 falling edge with everything masked: latches at N+3, no irq.
        irq_pins = 5'h1E;
        steps(3);
        peek(3'd2, 8'h00, "i0 before N+3");
        step();
        peek(3'd2, 8'h01, "i0 at N+3");
        step();
        chk("i0 masked irq", {7'b0, irq}, 8'h00);
        irq_pins = 5'h1F;
        wr(3'd7, 8'h01);
        steps(5);
        peek(3'd2, 8'h00, "i0 cleared");

        // Non-priority service of I2.
        wr(3'd5, 8'h1F);
        irq_pins = 5'h1B;
        steps(5);
        rd_chk(3'd2, 8'h24, "i2 rs2");
        rd_chk(3'd7, 8'h04, "i2 air");
        wr(3'd7, 8'h04);
        peek(3'd2, 8'h20, "i2 cleared irq lag");
        step();
        peek(3'd2, 8'h00, "i2 cleared");
        irq_pins = 5'h1F;
        steps(5);
        peek(3'd2, 8'h00, "i2 rise ignored");

        // I3 edge polarity select.
        wr(3'd6, 8'h02);
        irq_pins = 5'h17;
        steps(5);
        peek(3'd2, 8'h00, "i3 fall ignored");
        irq_pins = 5'h1F;
        steps(5);
        peek(3'd2, 8'h28, "i3 rise latched");
        wr(3'd7, 8'h08);
        wr(3'd6, 8'h00);
        irq_pins = 5'h17;
        steps(5);
        peek(3'd2, 8'h28, "i3 fall latched");
        wr(3'd7, 8'h08);
        irq_pins = 5'h1F;
        steps(5);
        peek(3'd2, 8'h00, "i3 cleared");

        // Priority mode: I1 then I4.
        wr(3'd6, 8'h01);
        irq_pins = 5'h1D;
        steps(2);
        irq_pins = 5'h0D;
        steps(6);
        chk("prio irq", {7'b0, irq}, 8'h01);
        rd_chk(3'd7, 8'h10, "prio air i4");
        step();
        chk("prio irq drop", {7'b0, irq}, 8'h00);
        wr(3'd7, 8'h00);
        step();
        chk("prio irq i1", {7'b0, irq}, 8'h01);
        rd_chk(3'd7, 8'h02, "prio air i1");
        wr(3'd7, 8'h00);
        step();
        chk("prio irq done", {7'b0, irq}, 8'h00);
        peek(3'd2, 8'h00, "prio ilr empty");
        irq_pins = 5'h1F;
        steps(5);

        // Nesting: I1 in service, I3 preempts.
        irq_pins = 5'h1D;
        steps(5);
        chk("nest irq i1", {7'b0, irq}, 8'h01);
        rd_chk(3'd7, 8'h02, "nest air i1");
        step();
        chk("nest irq low", {7'b0, irq}, 8'h00);
        irq_pins = 5'h15;
        steps(5);
        chk("nest irq i3", {7'b0, irq}, 8'h01);
        rd_chk(3'd7, 8'h08, "nest air i3");
        step();
        chk("nest irq low2", {7'b0, irq}, 8'h00);
        wr(3'd7, 8'h00);
        step();
        peek(3'd2, 8'h02, "nest eoi i3");
        peek(3'd7, 8'h00, "nest i1 still svc");
        wr(3'd7, 8'h00);
        step();
        peek(3'd2, 8'h00, "nest eoi i1");
        irq_pins = 5'h1F;
        steps(5);

        // Reset mid-service with ISR=0x0A and an I0 edge in flight.
        irq_pins = 5'h1D;
        steps(5);
        rd_chk(3'd7, 8'h02, "rst air i1");
        irq_pins = 5'h15;
        steps(5);
        rd_chk(3'd7, 8'h08, "rst air i3");
        irq_pins = 5'h1F;
        steps(4);
        irq_pins = 5'h1E;
        step();
        irq_pins = 5'h1F;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        peek(3'd2, 8'h00, "midrst rs2");
        peek(3'd5, 8'h00, "midrst rs5");
        peek(3'd6, 8'h00, "midrst rs6");
        peek(3'd7, 8'h00, "midrst rs7");
        steps(4);
        peek(3'd2, 8'h00, "midrst edge dropped");

        // Same-cycle edge set and AIR write clear: set wins.
        wr(3'd5, 8'h1F);
        irq_pins = 5'h1E;
        steps(5);
        irq_pins = 5'h1F;
        steps(5);
        irq_pins = 5'h1E;
        steps(3);
        wr(3'd7, 8'h01);
        peek(3'd2, 8'h21, "set beats clear");
        irq_pins = 5'h1F;
        wr(3'd7, 8'h01);
        step();
        peek(3'd2, 8'h00, "plain clear");

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int op;
            op = $urandom_range(0, 19);
            irq_pins = irq_pins ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            reset = (op == 19) && ($urandom_range(0, 9) == 0);
            sel = ($urandom_range(0, 7) != 0);
            data_in = 8'($urandom);
            rs = 3'($urandom);
            case (op)
                0, 1, 2: begin rs = 3'd7; rd_stb = 1'b1; end
                3, 4:    begin rs = 3'd7; wr_stb = 1'b1; end
                5:       begin rs = 3'd5; wr_stb = 1'b1; end
                6:       begin rs = 3'd6; wr_stb = 1'b1; end
                7, 8:    rd_stb = 1'b1;
                default: ;
            endcase
            step();
            rd_stb = 1'b0;
            wr_stb = 1'b0;
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
